// File: rtl/frame_buffer_reader.sv
// Raster-order read sequencer for frame_buffer with a 2-entry skid FIFO toward the edge-detect pipeline.
// States: IDLE wait for start | READ issue buffer reads | DRAIN flush FIFO | DONE one-cycle done pulse
module frame_buffer_reader #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic                           I_ENABLE,
    input  logic                           I_START,
    output logic [$clog2(P_COLUMNS)-1:0]   O_BUF_COL,
    output logic [$clog2(P_ROWS)-1:0]      O_BUF_ROW,
    output logic                           O_BUF_READ_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]       I_BUF_PIXEL,
    output logic [P_PIXEL_DEPTH-1:0]       O_PIXEL,
    output logic [$clog2(P_COLUMNS)-1:0]   O_PIXEL_COL,
    output logic [$clog2(P_ROWS)-1:0]      O_PIXEL_ROW,
    output logic                           O_LAST,
    output logic                           O_VALID,
    input  logic                           I_READY,
    output logic                           O_BUSY,
    output logic                           O_DONE
);

    localparam int COL_W = $clog2(P_COLUMNS);
    localparam int ROW_W = $clog2(P_ROWS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_W-1:0]         col_cnt;
    logic [ROW_W-1:0]         row_cnt;
    logic                     inflight;
    logic                     inflight_last;
    logic [COL_W-1:0]         inflight_col;
    logic [ROW_W-1:0]         inflight_row;

    logic [P_PIXEL_DEPTH-1:0] fifo_pixel [2];
    logic [COL_W-1:0]         fifo_col   [2];
    logic [ROW_W-1:0]         fifo_row   [2];
    logic [1:0]               fifo_last;
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;

    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     col_end;
    logic                     last_addr;
    logic [2:0]               fill_level;

    assign col_end   = (col_cnt == COL_W'(P_COLUMNS - 1));
    assign last_addr = col_end && (row_cnt == ROW_W'(P_ROWS - 1));
    assign push      = inflight;
    assign pop       = O_VALID && I_READY;

    // A read is only issued if its pixel is guaranteed a FIFO slot when it lands.
    assign fill_level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == ST_READ) && I_ENABLE && (fill_level < 3'd2);

    assign O_BUF_READ_ENABLE = issue;
    assign O_BUF_COL         = col_cnt;
    assign O_BUF_ROW         = row_cnt;
    assign O_VALID           = (count != 2'd0);
    assign O_PIXEL           = fifo_pixel[rd_ptr];
    assign O_PIXEL_COL       = fifo_col[rd_ptr];
    assign O_PIXEL_ROW       = fifo_row[rd_ptr];
    assign O_LAST            = fifo_last[rd_ptr];
    assign O_BUSY            = (state != ST_IDLE);
    assign O_DONE            = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (I_START) state_next = ST_READ;
            ST_READ:  if (issue && last_addr) state_next = ST_DRAIN;
            ST_DRAIN: if ((count == 2'd0) && !inflight) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            col_cnt       <= '0;
            row_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_col  <= '0;
            inflight_row  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_last <= last_addr;
                inflight_col  <= col_cnt;
                inflight_row  <= row_cnt;
                if (last_addr) begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                end else if (col_end) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    // Storage is cleared too so every output reads 0 right after reset.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pixel[i] <= '0;
                fifo_col[i]   <= '0;
                fifo_row[i]   <= '0;
            end
            fifo_last <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                fifo_pixel[wr_ptr] <= I_BUF_PIXEL;
                fifo_col[wr_ptr]   <= inflight_col;
                fifo_row[wr_ptr]   <= inflight_row;
                fifo_last[wr_ptr]  <= inflight_last;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: buffer model with 1-cycle latency and raster-order scoreboard.
module tb_frame_buffer_reader;

    localparam int COLS = 640;
    localparam int ROWS = 3;
    localparam int NPIX = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic        ready;
    logic [9:0]  buf_col;
    logic [1:0]  buf_row;
    logic        buf_re;
    logic [23:0] buf_pixel;
    logic [23:0] pixel;
    logic [9:0]  pixel_col;
    logic [1:0]  pixel_row;
    logic        last;
    logic        valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int out_idx;
    int sidx;
    int done_cnt;
    bit mon_on;
    bit prev_stall;
    logic [36:0] prev_head;

    typedef struct {
        int start, ready, enable;
        int ren, bcol, valid, pcol, busy;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    frame_buffer_reader dut (
        .I_CLK             (clk),
        .I_RESET           (reset),
        .I_ENABLE          (enable),
        .I_START           (start),
        .O_BUF_COL         (buf_col),
        .O_BUF_ROW         (buf_row),
        .O_BUF_READ_ENABLE (buf_re),
        .I_BUF_PIXEL       (buf_pixel),
        .O_PIXEL           (pixel),
        .O_PIXEL_COL       (pixel_col),
        .O_PIXEL_ROW       (pixel_row),
        .O_LAST            (last),
        .O_VALID           (valid),
        .I_READY           (ready),
        .O_BUSY            (busy),
        .O_DONE            (done)
    );

    function automatic logic [23:0] pix(int c, int r);
        if (c == 0 && r == 0) return 24'hFFFFFF;
        if (c == COLS - 1 && r == ROWS - 1) return 24'hFF0000;
        return {12'(r), 12'(c)};
    endfunction

    function automatic logic [36:0] exp_head(int idx);
        int c;
        int r;
        if (idx >= NPIX) return '1;
        c = idx % COLS;
        r = idx / COLS;
        return {(idx == NPIX - 1), 2'(r), 10'(c), pix(c, r)};
    endfunction

    // frame_buffer model: data for a strobed address appears one clock later
    always @(posedge clk) begin
        if (buf_re) buf_pixel <= pix(int'(buf_col), int'(buf_row));
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [36:0] head;
        head = {last, pixel_row, pixel_col, pixel};
        if (!mon_on) begin
            out_idx    = 0;
            sidx       = 0;
            done_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_stable", {valid, head}, {1'b1, prev_head});
            if (buf_re) begin
                check("strobe_addr", {buf_row, buf_col},
                      (sidx < NPIX) ? {2'(sidx / COLS), 10'(sidx % COLS)} : 12'hFFF);
                sidx++;
            end
            if (valid && ready) begin
                check("pixel_stream", head, exp_head(out_idx));
                out_idx++;
            end
            if (done) done_cnt++;
            prev_stall = valid && !ready;
            prev_head  = head;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        monitor();
    endtask

    task automatic check_all_zero(string name);
        check(name, {valid, busy, buf_re, done, last, buf_col, buf_row, pixel, pixel_col, pixel_row}, 64'd0);
    endtask

    task automatic new_frame();
        cyc();
        mon_on = 1'b0;
        smp();
        mon_on = 1'b1;
        cyc();
        start = 1'b1;
        smp();
    endtask

    task automatic run_until_done(bit rnd, int start_at, string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            cyc();
            start = (i == start_at);
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            smp();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        cyc();
        start = 1'b0;
        ready = 1'b1;
        smp();
        cyc();
        smp();
        check({tag, "_pixels"}, 64'(out_idx), 64'(NPIX));
        check({tag, "_strobes"}, 64'(sidx), 64'(NPIX));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_after"}, {busy, done, valid}, 64'd0);
    endtask

    initial begin
        bit hit;
        int nstrb;

        //           start ready en | ren bcol valid pcol busy
        vecs[0]  = '{1, 1, 1,  0, 0, 0, -1, 0};
        vecs[1]  = '{0, 1, 1,  1, 0, 0, -1, 1};
        vecs[2]  = '{0, 1, 1,  1, 1, 0, -1, 1};
        vecs[3]  = '{0, 0, 1,  0, 2, 1,  0, 1};
        vecs[4]  = '{0, 0, 1,  0, 2, 1,  0, 1};
        vecs[5]  = '{0, 1, 1,  1, 2, 1,  0, 1};
        vecs[6]  = '{0, 1, 0,  0, 3, 1,  1, 1};
        vecs[7]  = '{0, 1, 0,  0, 3, 1,  2, 1};
        vecs[8]  = '{0, 1, 0,  0, 3, 0, -1, 1};
        vecs[9]  = '{0, 1, 1,  1, 3, 0, -1, 1};
        vecs[10] = '{1, 1, 1,  1, 4, 0, -1, 1};
        vecs[11] = '{0, 1, 1,  1, 5, 1,  3, 1};

        reset  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        ready  = 1'b1;
        mon_on = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        smp();
        check_all_zero("reset_outputs");
        cyc();
        reset = 1'b1;
        smp();

        // Frame 1: cycle-exact start-up, stall and enable gaps, start while busy
        mon_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            start  = 1'(vecs[i].start);
            ready  = 1'(vecs[i].ready);
            enable = 1'(vecs[i].enable);
            smp();
            check($sformatf("vec%0d_ren", i), 64'(buf_re), 64'(vecs[i].ren));
            check($sformatf("vec%0d_buf_col", i), 64'(buf_col), 64'(vecs[i].bcol));
            check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].valid));
            if (vecs[i].pcol >= 0)
                check($sformatf("vec%0d_pix_col", i), 64'(pixel_col), 64'(vecs[i].pcol));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
        end
        run_until_done(1'b0, -1, "frame1");

        // Frame 2: enable gap at column 300, then a 10-cycle downstream stall in row 1
        new_frame();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            cyc();
            start = 1'b0;
            smp();
            hit = buf_re && (buf_col == 10'd299) && (buf_row == 2'd0);
        end
        check("wait_col299", 64'(hit), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            enable = 1'b0;
            smp();
            check("enable_hold", {buf_re, buf_row, buf_col}, {1'b0, 2'd0, 10'd300});
        end
        cyc();
        enable = 1'b1;
        smp();
        check("enable_resume", {buf_re, buf_row, buf_col}, {1'b1, 2'd0, 10'd300});
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc();
            smp();
            hit = (out_idx >= COLS + 100);
        end
        check("wait_pixel740", 64'(hit), 64'd1);
        nstrb = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            ready = 1'b0;
            smp();
            if (buf_re) nstrb++;
            check("stall_valid", 64'(valid), 64'd1);
        end
        check("stall_strobes_le2", 64'(nstrb <= 2), 64'd1);
        run_until_done(1'b0, -1, "frame2");

        // Frame 3: reset at pixel 100, then a full frame with random ready and a stray start
        new_frame();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            cyc();
            start = 1'b0;
            smp();
            hit = (out_idx >= 100);
        end
        check("wait_pixel100", 64'(hit), 64'd1);
        cyc();
        reset  = 1'b0;
        ready  = 1'b0;
        mon_on = 1'b0;
        smp();
        cyc();
        smp();
        check_all_zero("midframe_reset");
        cyc();
        reset = 1'b1;
        ready = 1'b1;
        smp();
        check_all_zero("after_reset_release");
        new_frame();
        run_until_done(1'b1, 500, "frame3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
